epw_tagged_alu: RTL and testbench

Parametrised, tagged arithmetic execution unit: the next-generation EPW operation processor. It accepts an opcode, two operands and a tag over a valid/ready handshake, and executes single-cycle ALU ops or an iterative multiply. Results carry their originating tag back through a DEPTH-entry in-order result FIFO with its own valid/ready handshake. It sits behind the EPW bus interface, replacing the fixed-width, non-backpressured datapath.

---
 rtl/epw_tagged_alu.sv | 218 +++++++++++++++++++++
 tb/tb_epw_tagged_alu.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/epw_tagged_alu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : epw_tagged_alu
// Brief    : Tagged ALU with iterative shift-add multiply and in-order result
//            FIFO. Define EPW_SAT_EN to saturate ADD/SUB/MUL instead of wrap.
// Revision : 1.0 - initial release
// ============================================================================
module epw_tagged_alu #(
   parameter int DATA_W = 16,
   parameter int TAG_W  = 4,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] data_a,
   input  logic [DATA_W-1:0] data_b,
   input  logic [TAG_W-1:0]  tag,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] result,
   output logic [TAG_W-1:0]  rtag,
   output logic              error
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SH_W  = $clog2(DATA_W);
   localparam int MC_W  = $clog2(DATA_W) + 1;
`ifdef EPW_SAT_EN
   localparam int ACC_W = 2 * DATA_W;
`else
   localparam int ACC_W = DATA_W;
`endif
   localparam logic [CNT_W-1:0] FULL_C    = CNT_W'(DEPTH);
   localparam logic [MC_W-1:0]  MUL_LEN_C = MC_W'(DATA_W);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL_BUSY = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [DATA_W-1:0] mem_res_q [DEPTH];
   logic [DATA_W-1:0] mem_res_d [DEPTH];
   logic [TAG_W-1:0]  mem_tag_q [DEPTH];
   logic [TAG_W-1:0]  mem_tag_d [DEPTH];
   logic              mem_err_q [DEPTH];
   logic              mem_err_d [DEPTH];
   logic [MC_W-1:0]   mcnt_q, mcnt_d;
   logic [ACC_W-1:0]  acc_q, acc_d, mcand_q, mcand_d;
   logic [DATA_W-1:0] mplier_q, mplier_d;
   logic [TAG_W-1:0]  mtag_q, mtag_d;

   logic              accept, pop, push;
   logic [DATA_W-1:0] push_res;
   logic [TAG_W-1:0]  push_tag;
   logic              push_err;
   logic [DATA_W-1:0] alu_res;
   logic              alu_err;
   logic [ACC_W-1:0]  acc_step;
   logic [DATA_W-1:0] mul_res;

   assign in_ready  = !reset && (state_q == S_IDLE) && (count_q < FULL_C);
   assign accept    = in_valid && in_ready;
   assign res_valid = (count_q != '0);
   assign pop       = res_valid && res_ready;
   assign result    = mem_res_q[rptr_q];
   assign rtag      = mem_tag_q[rptr_q];
   assign error     = mem_err_q[rptr_q];

   // Single-cycle ALU on the request operands
`ifdef EPW_SAT_EN
   logic [DATA_W:0] add_full;
   logic            borrow;
   assign add_full = {1'b0, data_a} + {1'b0, data_b};
   assign borrow   = (data_a < data_b);
`endif

   always_comb begin
      alu_res = '0;
      alu_err = 1'b0;
      case (op)
`ifdef EPW_SAT_EN
         OP_ADD: alu_res = add_full[DATA_W] ? '1 : add_full[DATA_W-1:0];
         OP_SUB: alu_res = borrow ? '0 : (data_a - data_b);
`else
         OP_ADD: alu_res = data_a + data_b;
         OP_SUB: alu_res = data_a - data_b;
`endif
         OP_AND: alu_res = data_a & data_b;
         OP_OR:  alu_res = data_a | data_b;
         OP_XOR: alu_res = data_a ^ data_b;
         OP_SHL: alu_res = data_a << data_b[SH_W-1:0];
         OP_MUL: alu_res = '0;
         default: alu_err = 1'b1;
      endcase
   end

   // One shift-add step; the final step's value is pushed directly
   assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
`ifdef EPW_SAT_EN
   assign mul_res = (|acc_step[ACC_W-1:DATA_W]) ? '1 : acc_step[DATA_W-1:0];
`else
   assign mul_res = acc_step;
`endif

   always_comb begin
      state_d  = state_q;
      mcnt_d   = mcnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      mtag_d   = mtag_q;
      push     = 1'b0;
      push_res = alu_res;
      push_tag = tag;
      push_err = alu_err;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (op == OP_MUL) begin
                  state_d  = S_MUL_BUSY;
                  mcnt_d   = MUL_LEN_C;
                  acc_d    = '0;
                  mcand_d  = ACC_W'(data_a);
                  mplier_d = data_b;
                  mtag_d   = tag;
               end else begin
                  push = 1'b1;
               end
            end
         end
         S_MUL_BUSY: begin
            mcnt_d   = mcnt_q - MC_W'(1);
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (mcnt_q == MC_W'(1)) begin
               push     = 1'b1;
               push_res = mul_res;
               push_tag = mtag_q;
               push_err = 1'b0;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // in_ready guarantees a free slot for every push, including the MUL result
   always_comb begin
      mem_res_d = mem_res_q;
      mem_tag_d = mem_tag_q;
      mem_err_d = mem_err_q;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      count_d   = count_q;
      if (push) begin
         mem_res_d[wptr_q] = push_res;
         mem_tag_d[wptr_q] = push_tag;
         mem_err_d[wptr_q] = push_err;
         wptr_d            = wptr_q + PTR_W'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         count_q  <= '0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         mcnt_q   <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         mtag_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_res_q[i] <= '0;
            mem_tag_q[i] <= '0;
            mem_err_q[i] <= 1'b0;
         end
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         mcnt_q    <= mcnt_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         mtag_q    <= mtag_d;
         mem_res_q <= mem_res_d;
         mem_tag_q <= mem_tag_d;
         mem_err_q <= mem_err_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_epw_tagged_alu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_epw_tagged_alu
// Brief    : Scoreboard bench for epw_tagged_alu (honours EPW_SAT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_epw_tagged_alu;

   localparam int DATA_W = 16;
   localparam int TAG_W  = 4;
   localparam int DEPTH  = 4;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_ILL = 3'b111;

`ifdef EPW_SAT_EN
   localparam logic [15:0] E_ADD_OVF = 16'hFFFF;
   localparam logic [15:0] E_SUB_UND = 16'h0000;
   localparam logic [15:0] E_MUL_BIG = 16'hFFFF;
`else
   localparam logic [15:0] E_ADD_OVF = 16'h0001;
   localparam logic [15:0] E_SUB_UND = 16'hFFFF;
   localparam logic [15:0] E_MUL_BIG = 16'h0000;
`endif

   typedef struct packed {
      logic [15:0] res;
      logic [3:0]  tag;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, res_valid, res_ready, error;
   logic [2:0]  op;
   logic [15:0] data_a, data_b, result;
   logic [3:0]  tag, rtag;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   epw_tagged_alu #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .data_a(data_a), .data_b(data_b), .tag(tag),
      .res_valid(res_valid), .res_ready(res_ready), .result(result),
      .rtag(rtag), .error(error)
   );

   function automatic exp_t mk(input logic [15:0] r, input logic [3:0] t, input logic e);
      exp_t x;
      x.res = r;
      x.tag = t;
      x.err = e;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: compares the FIFO head every cycle it is valid; pops on handshake
   always @(negedge clk) begin
      exp_t e;
      if (!reset && res_valid) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_result: got rtag 0x%0h result 0x%0h, expected none", rtag, result);
         end else begin
            e = sb[0];
            chk("result", {16'h0, result}, {16'h0, e.res});
            chk("rtag", {28'h0, rtag}, {28'h0, e.tag});
            chk("error", {31'h0, error}, {31'h0, e.err});
            if (res_ready) void'(sb.pop_front());
         end
      end
   end

   // Caller is in the posedge+1 phase; returns in the posedge+1 phase after accept
   task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] t, input exp_t e, input bit track);
      int waited = 0;
      op = o; data_a = a; data_b = b; tag = t; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && waited < 64) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_fail++;
         $display("FAIL accept_timeout: got in_ready 0 for tag 0x%0h, expected 1", t);
      end else if (track) begin
         sb.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int waited = 0;
      while (sb.size() != 0 && waited < 64) begin
         @(negedge clk);
         waited++;
      end
      chk("drain_left", sb.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      int lo;
      reset = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
      op = '0; data_a = '0; data_b = '0; tag = '0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", {31'h0, in_ready}, 0);
      chk("rst_res_valid", {31'h0, res_valid}, 0);
      chk("rst_result", {16'h0, result}, 0);
      chk("rst_rtag", {28'h0, rtag}, 0);
      chk("rst_error", {31'h0, error}, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("in_ready_after_rst", {31'h0, in_ready}, 1);
      res_ready = 1'b1;
      @(posedge clk); #1;

      issue(OP_ADD, 16'h1234, 16'h0001, 4'd3, mk(16'h1235, 4'd3, 1'b0), 1'b1);
      @(negedge clk);
      chk("add_latency_valid", {31'h0, res_valid}, 1);
      @(posedge clk); #1;

      issue(OP_ADD, 16'hFFFF, 16'h0002, 4'd1, mk(E_ADD_OVF, 4'd1, 1'b0), 1'b1);
      issue(OP_SUB, 16'h0001, 16'h0002, 4'd2, mk(E_SUB_UND, 4'd2, 1'b0), 1'b1);
      issue(OP_SUB, 16'h5000, 16'h1234, 4'd3, mk(16'h3DCC, 4'd3, 1'b0), 1'b1);
      issue(OP_AND, 16'hF0F0, 16'h0FF0, 4'd4, mk(16'h00F0, 4'd4, 1'b0), 1'b1);
      issue(OP_OR,  16'hF000, 16'h000F, 4'd5, mk(16'hF00F, 4'd5, 1'b0), 1'b1);
      issue(OP_XOR, 16'hAAAA, 16'hFFFF, 4'd6, mk(16'h5555, 4'd6, 1'b0), 1'b1);
      issue(OP_SHL, 16'h0003, 16'h0014, 4'd7, mk(16'h0030, 4'd7, 1'b0), 1'b1);
      wait_drain();

      issue(OP_MUL, 16'h0100, 16'h0100, 4'd5, mk(E_MUL_BIG, 4'd5, 1'b0), 1'b1);
      lo = 0;
      @(negedge clk);
      while (!in_ready && lo < 40) begin
         lo++;
         @(negedge clk);
      end
      chk("mul_busy_cycles", lo, 16);
      chk("mul_res_valid", {31'h0, res_valid}, 1);
      @(posedge clk); #1;
      issue(OP_MUL, 16'h0012, 16'h0003, 4'd6, mk(16'h0036, 4'd6, 1'b0), 1'b1);
      wait_drain();

      issue(OP_ILL, 16'hABCD, 16'h1234, 4'd9,  mk(16'h0000, 4'd9, 1'b1), 1'b1);
      issue(OP_ADD, 16'h0002, 16'h0003, 4'd10, mk(16'h0005, 4'd10, 1'b0), 1'b1);
      wait_drain();

      // Fill the FIFO, then pop once while a new request is waiting
      res_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         issue(OP_ADD, 16'(i), 16'h0010, 4'(i), mk(16'h0010 + 16'(i), 4'(i), 1'b0), 1'b1);
      end
      @(negedge clk);
      chk("full_in_ready", {31'h0, in_ready}, 0);
      @(posedge clk); #1;
      op = OP_ADD; data_a = 16'h0100; data_b = 16'h0001; tag = 4'd12;
      in_valid = 1'b1; res_ready = 1'b1;
      @(negedge clk);
      chk("full_offer_blocked", {31'h0, in_ready}, 0);
      @(posedge clk); #1;
      res_ready = 1'b0;
      @(negedge clk);
      chk("in_ready_after_pop", {31'h0, in_ready}, 1);
      sb.push_back(mk(16'h0101, 4'd12, 1'b0));
      @(posedge clk); #1;
      in_valid = 1'b0;
      res_ready = 1'b1;
      wait_drain();

      // Reset during MUL cycle 7: no result may appear afterwards
      issue(OP_MUL, 16'h1234, 16'h0002, 4'd7, mk(16'h2468, 4'd7, 1'b0), 1'b0);
      repeat (6) @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_in_ready", {31'h0, in_ready}, 0);
      chk("rst_mid_res_valid", {31'h0, res_valid}, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("in_ready_after_mid_rst", {31'h0, in_ready}, 1);
      chk("res_valid_after_mid_rst", {31'h0, res_valid}, 0);
      repeat (24) @(negedge clk);
      chk("sb_empty_end", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
